// File: rtl/micro_div_pkg.sv
// Shared types and helpers for the micro divider tile.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package micro_div_pkg;

    localparam int DEF_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Ceiling log2, never below 1 so a counter always has at least one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/micro_div_njp_if.sv
// Start/done handshake and operand/result bus of the micro divider.
// Latency: n/a (wiring only).
// Backpressure: none; start is only honoured while the divider is idle.
interface micro_div_njp_if #(
    parameter int W = micro_div_pkg::DEF_W
);
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/micro_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract.
// Latency: combinational.
// Backpressure: n/a.
module micro_div_step #(
    parameter int W = 8
) (
    input  logic [W-1:0] rem_i,
    input  logic         q_msb_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] rem_o,
    output logic         q_bit_o
);

    logic [W:0] shifted;
    logic       ge;

    // Compare at W+1 bits so the shifted partial remainder cannot overflow;
    // when it is >= divisor the difference always fits back into W bits.
    always_comb begin
        shifted = {rem_i, q_msb_i};
        ge      = (shifted >= {1'b0, divisor_i});
        q_bit_o = ge;
        rem_o   = ge ? (shifted[W-1:0] - divisor_i) : shifted[W-1:0];
    end

endmodule

// File: rtl/micro_div_njp.sv
// Iterative restoring divider, one quotient bit per clock (MICRO_DIV_SIGNED_EN: two's complement).
// Latency: W+1 edges from accepted start to done; 1 edge for divide-by-zero.
// Backpressure: start ignored unless IDLE; one op per W+2 cycles.
module micro_div_njp
    import micro_div_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic           clk,
    input  logic           rst,
    micro_div_njp_if.slave bus
);

    localparam int             CW       = clog2(W);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(W - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  q_q, q_d;
    logic [W-1:0]  div_q, div_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  rmd_q, rmd_d;
    logic          dbz_q, dbz_d;
    logic          done_q, done_d;

    logic [W-1:0]  step_rem;
    logic          step_qbit;

    logic [W-1:0]  ld_a, ld_b;
    logic [W-1:0]  res_quo, res_rem;
    logic [W-1:0]  dbz_quo, dbz_rem;

`ifdef MICRO_DIV_SIGNED_EN
    logic          a_neg_q, a_neg_d;
    logic          b_neg_q, b_neg_d;
`endif

    micro_div_step #(.W(W)) u_step (
        .rem_i     (rem_q),
        .q_msb_i   (q_q[W-1]),
        .divisor_i (div_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_qbit)
    );

    // Operand conditioning at load and result fix-up in the DONE cycle.
    always_comb begin
`ifdef MICRO_DIV_SIGNED_EN
        ld_a    = bus.dividend[W-1] ? -bus.dividend : bus.dividend;
        ld_b    = bus.divisor[W-1]  ? -bus.divisor  : bus.divisor;
        res_quo = (a_neg_q ^ b_neg_q) ? -q_q : q_q;
        res_rem = a_neg_q ? -rem_q : rem_q;
        dbz_quo = a_neg_q ? W'(1) : '1;
        dbz_rem = a_neg_q ? -q_q : q_q;
`else
        ld_a    = bus.dividend;
        ld_b    = bus.divisor;
        res_quo = q_q;
        res_rem = rem_q;
        dbz_quo = '1;
        dbz_rem = q_q;
`endif
    end

    // Next-state logic: IDLE -> RUN (or straight to DONE on zero divisor) -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = (bus.divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: load on accept, one step per RUN cycle, publish in DONE.
    always_comb begin
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        q_d    = q_q;
        div_d  = div_q;
        quo_d  = quo_q;
        rmd_d  = rmd_q;
        dbz_d  = dbz_q;
        done_d = 1'b0;
`ifdef MICRO_DIV_SIGNED_EN
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    rem_d = '0;
                    q_d   = ld_a;
                    div_d = ld_b;
                    cnt_d = CNT_LOAD;
                    dbz_d = 1'b0;
`ifdef MICRO_DIV_SIGNED_EN
                    a_neg_d = bus.dividend[W-1];
                    b_neg_d = bus.divisor[W-1];
`endif
                end
            end
            RUN: begin
                rem_d = step_rem;
                q_d   = {q_q[W-2:0], step_qbit};
                cnt_d = cnt_q - CW'(1);
            end
            DONE: begin
                done_d = 1'b1;
                if (div_q == '0) begin
                    dbz_d = 1'b1;
                    quo_d = dbz_quo;
                    rmd_d = dbz_rem;
                end else begin
                    quo_d = res_quo;
                    rmd_d = res_rem;
                end
            end
            default: ;
        endcase
    end

    // State and datapath registers; reset aborts any division in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            div_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef MICRO_DIV_SIGNED_EN
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            div_q   <= div_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
`ifdef MICRO_DIV_SIGNED_EN
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
`endif
        end
    end

    assign bus.busy        = (state_q == RUN);
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rmd_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_micro_div_njp.sv
// Self-checking bench for micro_div_njp (W=8); honours MICRO_DIV_SIGNED_EN.
// Expected results are queued on each start and compared when done pulses.
module tb_micro_div_njp;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } vec_t;

    logic clk;
    logic rst;

    micro_div_njp_if #(.W(W)) bus ();

    micro_div_njp #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_push   = 0;
    int   done_cnt = 0;
    logic done_prev = 1'b0;
    exp_t sb_q[$];
    vec_t vecs[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: language division, independent of the restoring algorithm.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
`ifdef MICRO_DIV_SIGNED_EN
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        if (b == '0) begin
            e.q   = a[W-1] ? 8'd1 : 8'hFF;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
            e.q   = 8'(sa / sb);
            e.r   = 8'(sa % sb);
            e.dbz = 1'b0;
        end
`else
        if (b == '0) begin
            e.q   = 8'hFF;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 1'b0;
        end
`endif
        return e;
    endfunction

    task automatic add_vec(input logic [W-1:0] a, b, q, r, input logic dbz);
        vec_t v;
        v.a = a; v.b = b; v.q = q; v.r = r; v.dbz = dbz;
        vecs.push_back(v);
    endtask

    task automatic push_exp(input exp_t e);
        sb_q.push_back(e);
        n_push++;
    endtask

    // Called at a negedge with the divider idle; returns at the done negedge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
        int lat;
        int bcnt;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        push_exp(e);
        lat  = 0;
        bcnt = 0;
        do begin
            @(negedge clk);
            lat++;
            bus.start    = 1'b0;
            bus.dividend = ~a;
            bus.divisor  = b ^ 8'h5A;
            if (bus.busy) bcnt++;
        end while (!bus.done && lat < 40);
        if (!bus.done) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: no done after %0d cycles for %0h/%0h", lat, a, b);
        end else begin
            chk("latency", lat, (b == '0) ? 2 : W + 2);
            chk("busy_cycles", bcnt, (b == '0) ? 0 : W);
        end
    endtask

    // Scoreboard monitor: every done pops one expectation.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            done_cnt++;
            chk("done_while_busy", bus.busy, 0);
            chk("done_one_cycle", done_prev, 0);
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: q=%0h r=%0h, expected no done", bus.quotient, bus.remainder);
            end else begin
                mon_e = sb_q.pop_front();
                chk("quotient", bus.quotient, mon_e.q);
                chk("remainder", bus.remainder, mon_e.r);
                chk("div_by_zero", bus.div_by_zero, mon_e.dbz);
            end
        end
        done_prev = rst ? 1'b0 : bus.done;
    end

    initial begin
        int lat;
        int snap;
        exp_t e;

        clk          = 1'b0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

`ifdef MICRO_DIV_SIGNED_EN
        add_vec(8'd100, 8'd7,   8'd14,  8'd2,   1'b0);
        add_vec(8'hF9,  8'd2,   8'hFD,  8'hFF,  1'b0);
        add_vec(8'd7,   8'hFE,  8'hFD,  8'd1,   1'b0);
        add_vec(8'h80,  8'hFF,  8'h80,  8'd0,   1'b0);
        add_vec(8'hFB,  8'd0,   8'd1,   8'hFB,  1'b1);
        add_vec(8'd9,   8'd3,   8'd3,   8'd0,   1'b0);
        add_vec(8'd5,   8'd0,   8'hFF,  8'd5,   1'b1);
        add_vec(8'h80,  8'd1,   8'h80,  8'd0,   1'b0);
        add_vec(8'h81,  8'h7F,  8'hFF,  8'd0,   1'b0);
`else
        add_vec(8'd100, 8'd7,   8'd14,  8'd2,   1'b0);
        add_vec(8'd200, 8'd0,   8'd255, 8'd200, 1'b1);
        add_vec(8'd9,   8'd3,   8'd3,   8'd0,   1'b0);
        add_vec(8'd0,   8'd5,   8'd0,   8'd0,   1'b0);
        add_vec(8'd255, 8'd1,   8'd255, 8'd0,   1'b0);
        add_vec(8'd255, 8'd255, 8'd1,   8'd0,   1'b0);
        add_vec(8'd1,   8'd255, 8'd0,   8'd1,   1'b0);
        add_vec(8'd128, 8'd2,   8'd64,  8'd0,   1'b0);
        add_vec(8'd7,   8'd8,   8'd0,   8'd7,   1'b0);
        add_vec(8'd0,   8'd0,   8'd255, 8'd0,   1'b1);
        add_vec(8'd254, 8'd127, 8'd2,   8'd0,   1'b0);
`endif

        // Reset state
        #12;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_quotient", bus.quotient, 0);
        chk("rst_remainder", bus.remainder, 0);
        chk("rst_dbz", bus.div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Table vectors, back to back
        for (int i = 0; i < vecs.size(); i++) begin
            e.q   = vecs[i].q;
            e.r   = vecs[i].r;
            e.dbz = vecs[i].dbz;
            run_op(vecs[i].a, vecs[i].b, e);
        end

        // start held high, operands wiggled during RUN, next op right after done
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'd255;
        bus.divisor  = 8'd16;
        push_exp(model(8'd255, 8'd16));
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!bus.done) begin
                bus.dividend = 8'($urandom);
                bus.divisor  = 8'($urandom);
            end
        end while (!bus.done && lat < 40);
        chk("held_start_latency", lat, W + 2);
        bus.dividend = 8'd9;
        bus.divisor  = 8'd4;
        push_exp(model(8'd9, 8'd4));
        @(negedge clk);
        chk("b2b_accept_busy", bus.busy, 1);
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_latency", lat, W + 2);

        // Asynchronous reset in RUN cycle 4 aborts without done
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'd200;
        bus.divisor  = 8'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_abort_busy", bus.busy, 1);
        snap = done_cnt;
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_quotient", bus.quotient, 0);
        chk("abort_remainder", bus.remainder, 0);
        chk("abort_done", bus.done, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (W + 4) @(negedge clk);
        chk("abort_no_done", done_cnt, snap);
        run_op(8'd50, 8'd5, model(8'd50, 8'd5));

        // Strided sweep over the operand space, including zero divisors
        for (int a = 0; a < 256; a += 7) begin
            for (int b = 0; b < 256; b += 11) begin
                run_op(8'(a), 8'(b), model(8'(a), 8'(b)));
            end
        end

        // Random operands
        for (int i = 0; i < 200; i++) begin
            logic [W-1:0] ra, rb;
            ra = 8'($urandom_range(0, 255));
            rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            run_op(ra, rb, model(ra, rb));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);
        chk("done_count", done_cnt, n_push);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
